// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - fetch/loader arbiter and 4-byte big-endian sequencer
// for a single-port synchronous-read byte RAM.
module imem_fetch_ctrl #(
  parameter int ADDR_W      = 15,
  parameter bit LD_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base;
  logic [1:0]        cnt;
  logic [23:0]       instr;
  logic              accept;

  // Address bits above the RAM size are deliberately dropped.
  logic addr_hi_unused;
  assign addr_hi_unused = ^fetch_addr[31:ADDR_W];

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    fetch_ready = 1'b0;
    ld_ready    = 1'b0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (LD_PRIORITY) begin
          ld_ready    = 1'b1;
          fetch_ready = !ld_valid;
        end else begin
          ld_ready    = !fetch_req;
          fetch_ready = 1'b1;
        end
        if (ld_valid && ld_ready) begin
          mem_we    = 1'b1;
          mem_addr  = ld_addr;
          mem_wdata = ld_data;
        end
        if (fetch_req && fetch_ready) begin
          accept    = 1'b1;
          state_nxt = RD;
        end
      end
      RD: begin
        mem_addr = base + ADDR_W'(cnt);
        if (cnt == 2'd3) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Read data lags the address by one cycle, so the byte for cnt=N
  // is shifted in during the cycle with cnt=N+1 (or DRAIN for the last one).
  always_ff @(posedge clk) begin
    if (rst) begin
      base        <= '0;
      cnt         <= 2'd0;
      instr       <= 24'd0;
      fetch_instr <= 32'd0;
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            base <= fetch_addr[ADDR_W-1:0];
            cnt  <= 2'd0;
          end
        end
        RD: begin
          cnt <= cnt + 2'd1;
          if (cnt != 2'd0) begin
            instr <= {instr[15:0], mem_rdata};
          end
        end
        DRAIN: begin
          fetch_instr <= {instr, mem_rdata};
          fetch_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - scoreboard bench for imem_fetch_ctrl, both loader
// priority settings, with behavioural byte RAMs.
module tb_imem_fetch_ctrl;

  localparam int AW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          fetch_req, fetch_ready, fetch_valid, ld_valid, ld_ready, mem_we, busy;
  logic [31:0]   fetch_addr, fetch_instr;
  logic [AW-1:0] ld_addr, mem_addr;
  logic [7:0]    ld_data, mem_wdata, mem_rdata;

  logic          fetch_req_b, fetch_ready_b, fetch_valid_b, ld_valid_b, ld_ready_b, mem_we_b, busy_b;
  logic [31:0]   fetch_addr_b, fetch_instr_b;
  logic [AW-1:0] ld_addr_b, mem_addr_b;
  logic [7:0]    ld_data_b, mem_wdata_b, mem_rdata_b;

  imem_fetch_ctrl #(.ADDR_W(AW), .LD_PRIORITY(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  imem_fetch_ctrl #(.ADDR_W(AW), .LD_PRIORITY(1'b0)) u_dut_b (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req_b), .fetch_addr(fetch_addr_b), .fetch_ready(fetch_ready_b),
    .fetch_valid(fetch_valid_b), .fetch_instr(fetch_instr_b),
    .ld_valid(ld_valid_b), .ld_addr(ld_addr_b), .ld_data(ld_data_b), .ld_ready(ld_ready_b),
    .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
    .busy(busy_b)
  );

  logic [7:0]    ram_a [0:(1<<AW)-1];
  logic [7:0]    ram_b [0:(1<<AW)-1];
  logic          bd_we_a, bd_we_b;
  logic [AW-1:0] bd_addr;
  logic [7:0]    bd_data;

  always @(posedge clk) begin
    if (bd_we_a) ram_a[bd_addr] <= bd_data;
    else if (mem_we) ram_a[mem_addr] <= mem_wdata;
    mem_rdata <= ram_a[mem_addr];
  end

  always @(posedge clk) begin
    if (bd_we_b) ram_b[bd_addr] <= bd_data;
    else if (mem_we_b) ram_b[mem_addr_b] <= mem_wdata_b;
    mem_rdata_b <= ram_b[mem_addr_b];
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] instr;
    int          due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitors: pop the oldest expected fetch whenever a valid pulse shows up.
  logic pv_a = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && fetch_valid) begin
      chk("valid_width_a", {31'd0, pv_a}, 32'd0);
      if (q_a.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid_a: fetch_valid=1 instr=0x%08h, expected no pulse", fetch_instr);
      end else begin
        e = q_a.pop_front();
        chk("instr_a", fetch_instr, e.instr);
        chk("latency_a", cyc, e.due);
      end
    end
    pv_a <= fetch_valid;
  end

  logic pv_b = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && fetch_valid_b) begin
      chk("valid_width_b", {31'd0, pv_b}, 32'd0);
      if (q_b.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid_b: fetch_valid=1 instr=0x%08h, expected no pulse", fetch_instr_b);
      end else begin
        e = q_b.pop_front();
        chk("instr_b", fetch_instr_b, e.instr);
        chk("latency_b", cyc, e.due);
      end
    end
    pv_b <= fetch_valid_b;
  end

  task automatic poke(input bit sel_b, input int addr, input logic [7:0] d);
    bd_addr = addr[AW-1:0];
    bd_data = d;
    if (sel_b) bd_we_b = 1'b1;
    else bd_we_a = 1'b1;
    @(negedge clk);
    bd_we_a = 1'b0;
    bd_we_b = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic fetch_a(input logic [31:0] a, input logic [31:0] exp);
    int   n;
    exp_t e;
    n = 0;
    fetch_req  = 1'b1;
    fetch_addr = a;
    #1;
    while (!fetch_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept_a", {31'd0, fetch_ready}, 32'd1);
    if (fetch_ready) begin
      e.instr = exp;
      e.due   = cyc + 6;
      q_a.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic rd_seq_a(input logic [AW-1:0] base);
    logic [AW-1:0] ex;
    for (int i = 0; i < 4; i++) begin
      #1;
      ex = base + AW'(i);
      chk("rd_addr", {17'd0, mem_addr}, {17'd0, ex});
      chk("rd_we", {31'd0, mem_we}, 32'd0);
      chk("rd_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    #1;
    chk("drain_addr", {17'd0, mem_addr}, 32'd0);
    chk("drain_we", {31'd0, mem_we}, 32'd0);
  endtask

  task automatic drain_q(input bit sel_b);
    int n;
    n = 0;
    while ((sel_b ? q_b.size() : q_a.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(sel_b ? "drain_b" : "drain_a", sel_b ? q_b.size() : q_a.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    fetch_req = 0; fetch_addr = 0; ld_valid = 0; ld_addr = 0; ld_data = 0;
    fetch_req_b = 0; fetch_addr_b = 0; ld_valid_b = 0; ld_addr_b = 0; ld_data_b = 0;
    bd_we_a = 0; bd_we_b = 0; bd_addr = 0; bd_data = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_instr", fetch_instr, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {17'd0, mem_addr}, 32'd0);
    chk("rst_fready", {31'd0, fetch_ready}, 32'd1);
    chk("rst_lready", {31'd0, ld_ready}, 32'd1);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
    @(negedge clk);

    // Basic aligned fetch.
    poke(0, 32'h100, 8'h13); poke(0, 32'h101, 8'h05);
    poke(0, 32'h102, 8'h00); poke(0, 32'h103, 8'h00);
    fetch_a(32'h100, 32'h13050000);
    fetch_req = 1'b0;
    rd_seq_a(15'h100);
    drain_q(0);

    // Wrap at the top of memory, then upper address bits ignored.
    poke(0, 32'h7FFE, 8'hAA); poke(0, 32'h7FFF, 8'hBB);
    poke(0, 32'h0000, 8'hCC); poke(0, 32'h0001, 8'hDD);
    fetch_a(32'h0000_7FFE, 32'hAABBCCDD);
    fetch_req = 1'b0;
    rd_seq_a(15'h7FFE);
    drain_q(0);
    fetch_a(32'hFFFF_0100, 32'h13050000);
    fetch_req = 1'b0;
    drain_q(0);

    // Loader writes four bytes, fetch reads them back.
    poke(0, 32'h21, 8'hFF); poke(0, 32'h22, 8'hFF); poke(0, 32'h23, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_addr  = AW'(32'h20 + i);
      ld_data  = (i == 0) ? 8'h6F : 8'h00;
      #1;
      chk("ld_ready", {31'd0, ld_ready}, 32'd1);
      chk("ld_we", {31'd0, mem_we}, 32'd1);
      chk("ld_addr", {17'd0, mem_addr}, 32'h20 + i);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    fetch_a(32'h20, 32'h6F000000);
    fetch_req = 1'b0;
    drain_q(0);

    // Loader priority: simultaneous requests, write wins.
    poke(0, 32'h30, 8'hEE); poke(0, 32'h31, 8'h01);
    poke(0, 32'h32, 8'h02); poke(0, 32'h33, 8'h03);
    ld_valid = 1'b1; ld_addr = 15'h30; ld_data = 8'h5A;
    fetch_req = 1'b1; fetch_addr = 32'h30;
    #1;
    chk("arb_fready", {31'd0, fetch_ready}, 32'd0);
    chk("arb_lready", {31'd0, ld_ready}, 32'd1);
    chk("arb_we", {31'd0, mem_we}, 32'd1);
    chk("arb_addr", {17'd0, mem_addr}, 32'h30);
    chk("arb_wdata", {24'd0, mem_wdata}, 32'h5A);
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    chk("arb_fready_drop", {31'd0, fetch_ready}, 32'd1);
    fetch_a(32'h30, 32'h5A010203);
    fetch_req = 1'b0;
    ld_valid = 1'b1; ld_addr = 15'h40; ld_data = 8'h99;
    #1;
    chk("stall_lready", {31'd0, ld_ready}, 32'd0);
    chk("stall_we", {31'd0, mem_we}, 32'd0);
    ld_valid = 1'b0;
    drain_q(0);

    // Back-to-back fetches with fetch_req held high.
    for (int i = 0; i < 8; i++) poke(0, i, 8'(i + 1));
    fetch_a(32'h0, 32'h01020304);
    fetch_addr = 32'h4;
    repeat (5) @(negedge clk);
    #1;
    chk("b2b_ready", {31'd0, fetch_ready}, 32'd1);
    chk("b2b_coincide", {31'd0, fetch_valid}, 32'd1);
    fetch_a(32'h4, 32'h05060708);
    fetch_req = 1'b0;
    drain_q(0);

    // Reset during the third RD cycle.
    fetch_req = 1'b1; fetch_addr = 32'h100;
    #1;
    chk("rst_mid_accept", {31'd0, fetch_ready}, 32'd1);
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_mid_instr", fetch_instr, 32'd0);
    repeat (8) @(negedge clk);
    fetch_a(32'h100, 32'h13050000);
    fetch_req = 1'b0;
    drain_q(0);

    // Fetch priority (second instance): fetch wins, loader waits for IDLE.
    poke(1, 32'h10, 8'h11); poke(1, 32'h11, 8'h22);
    poke(1, 32'h12, 8'h33); poke(1, 32'h13, 8'h44);
    poke(1, 32'h50, 8'hEE); poke(1, 32'h51, 8'h00);
    poke(1, 32'h52, 8'h00); poke(1, 32'h53, 8'h00);
    fetch_req_b = 1'b1; fetch_addr_b = 32'h10;
    ld_valid_b = 1'b1; ld_addr_b = 15'h50; ld_data_b = 8'h77;
    #1;
    chk("b_fready", {31'd0, fetch_ready_b}, 32'd1);
    chk("b_lready", {31'd0, ld_ready_b}, 32'd0);
    chk("b_we", {31'd0, mem_we_b}, 32'd0);
    e.instr = 32'h11223344; e.due = cyc + 6;
    q_b.push_back(e);
    @(negedge clk);
    fetch_req_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("b_stall_lready", {31'd0, ld_ready_b}, 32'd0);
      chk("b_stall_we", {31'd0, mem_we_b}, 32'd0);
      @(negedge clk);
    end
    #1;
    chk("b_idle_lready", {31'd0, ld_ready_b}, 32'd1);
    chk("b_idle_we", {31'd0, mem_we_b}, 32'd1);
    chk("b_idle_addr", {17'd0, mem_addr_b}, 32'h50);
    @(negedge clk);
    ld_valid_b = 1'b0;
    fetch_req_b = 1'b1; fetch_addr_b = 32'h50;
    #1;
    chk("b_fready2", {31'd0, fetch_ready_b}, 32'd1);
    e.instr = 32'h77000000; e.due = cyc + 6;
    q_b.push_back(e);
    @(negedge clk);
    fetch_req_b = 1'b0;
    drain_q(1);

    repeat (4) @(negedge clk);
    chk("final_q_a", q_a.size(), 32'd0);
    chk("final_q_b", q_b.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
